qc_link_driver: RTL and testbench
=================================

# qc_link_driver

Host-side driver for the quantum-computer FSM's byte-toggle load/readback link. It takes the opposite end of the GPIO-style protocol the FSM consumes and drives it from fabric, so no MicroBlaze is needed. It streams state and gate bytes in from an upstream valid/ready source and drives them across the link. It then clocks the result vector back out and presents it on a downstream valid/ready stream. It sits between a test/host byte source and the FSM's `load_temp` / `load_ready` / `send_temp` pins.

## Interface
- `N`, 2: qubit count; vector length `2**N`.
- `HOLD_CYCLES`, 4: cycles each strobe level is held before the next byte; legal minimum is 2.
- `SETTLE_CYCLES`, 8: idle cycles between the last load byte and the first readback toggle, covering multiplier latency.
- `clk` in 1: the block's only clock; all logic is on its rising edge.
- `reset` in 1: asynchronous, active-high; the FSM on the other end of the link shares this reset.
- `start` in 1: one-cycle pulse that begins a transaction; ignored unless the block is in IDLE.
- `in_data` in 8: load byte, two's-complement.
- `in_valid` in 1 / `in_ready` out 1: upstream handshake; a byte transfers on a cycle where both are high.
- `out_data` out 8: readback byte.
- `out_valid` out 1 / `out_ready` in 1: downstream handshake.
- `link_data` out 8: drives the FSM's `load_temp`.
- `link_strobe` out 1: drives the FSM's `load_ready`.
- `link_rdata` in 8: from the FSM's `send_temp`.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse when a transaction ends.
- `cksum` out 8: running XOR checksum; see Configuration.

## Operation
- `LOAD_BYTES = 2*(2**N + 4**N)`, sent in this order:
  - state vector first, real byte then imaginary byte per element, index 0 upward;
  - then the gate matrix row-major, real byte then imaginary byte per element.
- `RESP_BYTES = 2*2**N`: output vector, real byte then imaginary byte per element, index 0 upward.
- Byte counter width is `$clog2(LOAD_BYTES+1)`.
- Byte k is signalled by toggling `link_strobe`: even k raises it, odd k lowers it. Both byte counts are even, so the strobe ends every phase low.
- States and transitions:
  - IDLE: on `start` -> LOAD_REQ; clear the counter and `cksum`.
  - LOAD_REQ: `in_ready=1`. On handshake: `link_data<=in_data` -> LOAD_SETUP.
  - LOAD_SETUP (1 cycle): `link_strobe<=~link_strobe` -> LOAD_HOLD.
  - LOAD_HOLD (HOLD_CYCLES cycles): at the end, go to SETTLE if this was the last load byte, else LOAD_REQ.
  - SETTLE (SETTLE_CYCLES cycles) -> READ_TOGGLE.
  - READ_TOGGLE (1 cycle): toggle `link_strobe` -> READ_HOLD.
  - READ_HOLD (HOLD_CYCLES cycles): on the final edge `out_data<=link_rdata` and `out_valid<=1` -> READ_OUT.
  - READ_OUT: hold `out_data`/`out_valid` until `out_ready`. On handshake `out_valid<=0`, then go to DONE if this was the last response byte, else READ_TOGGLE.
  - DONE (1 cycle): `done=1` -> IDLE.
- `in_ready` and `busy` are decoded from the registered state. `out_valid` is a register.
- `link_data` holds its last value outside LOAD states.
- Upstream stalls (`in_valid` low) and downstream stalls (`out_ready` low) are unbounded and never disturb the strobe level.

## Timing
- Reset values: IDLE; `link_strobe=0`, `link_data=0`, `out_data=0`, `out_valid=0`, `in_ready=0`, `busy=0`, `done=0`, `cksum=0`.
- Setup and hold on the link:
  - `link_data` is stable one full cycle before each load strobe edge.
  - The strobe level is held HOLD_CYCLES cycles after each edge.
  - Minimum cost is HOLD_CYCLES+2 cycles per load byte.
- Readback capture happens HOLD_CYCLES cycles after the toggle edge, which leaves time for the FSM to register `send_temp`.
- `start` on the same cycle as DONE is ignored.
- A `start` pulse while busy is ignored.
- Reset mid-transaction aborts immediately to IDLE. The partial transaction is lost and both ends resynchronize because they share the reset.

## Configuration
- `QC_LINK_CKSUM_EN` defined:
  - `cksum` accumulates the XOR of every accepted load byte and every delivered response byte.
  - It is cleared on `start` and holds its value after DONE.
- `QC_LINK_CKSUM_EN` undefined: `cksum` is tied to 0 and the accumulator is not built.

## Test plan
- Reset, then pulse `start` with N=2 and HOLD_CYCLES=4 -> `in_ready` rises the next cycle and `link_strobe=0`.
- Stream 40 bytes 0x01..0x28 back-to-back ->
  - the strobe makes 40 toggles, each level held 4 cycles;
  - `link_data` leads each edge by 1 cycle;
  - the final strobe level is 0.
- Against the FSM model with state=[1,0,0,0] and gate=identity (real parts 0x01) -> readback bytes are 01,00,00,00,00,00,00,00, then `done` pulses once.
- Hold `out_ready=0` for 20 cycles at response byte 3 -> `out_valid` and `out_data` remain stable, the strobe does not toggle, and the remaining bytes then complete.
- Assert `reset` after load byte 17 -> all outputs return to their reset values the same cycle; a fresh `start` completes a full transaction correctly.
- With `QC_LINK_CKSUM_EN`, send 40 bytes all 0x55 and receive 8 bytes 0x0F -> `cksum=0x00`. Send a single load byte 0xA5 with all others 0x00 and responses 0x00 -> `cksum=0xA5`.

Source files
------------

// File: rtl/qc_link_driver.sv
// Host-side driver for the quantum-computer FSM byte-toggle load/readback link.
// Optional running XOR checksum enabled by defining QC_LINK_CKSUM_EN.
module qc_link_driver #(
    parameter int N             = 2,
    parameter int HOLD_CYCLES   = 4,
    parameter int SETTLE_CYCLES = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] link_data,
    output logic       link_strobe,
    input  logic [7:0] link_rdata,
    output logic       busy,
    output logic       done,
    output logic [7:0] cksum
);
    localparam int VLEN       = 2 ** N;
    localparam int LOAD_BYTES = 2 * (VLEN + VLEN * VLEN);
    localparam int RESP_BYTES = 2 * VLEN;
    localparam int CW         = $clog2(LOAD_BYTES + 1);
    localparam int TMAX       = (HOLD_CYCLES > SETTLE_CYCLES) ? HOLD_CYCLES : SETTLE_CYCLES;
    localparam int TW         = $clog2(TMAX + 1);

    typedef enum logic [3:0] {
        IDLE, LOAD_REQ, LOAD_SETUP, LOAD_HOLD, SETTLE,
        READ_TOGGLE, READ_HOLD, READ_OUT, DONE
    } state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt;
    logic [TW-1:0] tmr;
    logic          hold_end, settle_end, load_last, resp_last;

    assign hold_end   = (tmr == TW'(HOLD_CYCLES - 1));
    assign settle_end = (tmr == TW'(SETTLE_CYCLES - 1));
    assign load_last  = (cnt == CW'(LOAD_BYTES));
    assign resp_last  = (cnt == CW'(RESP_BYTES - 1));

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        busy      = (state != IDLE);
        done      = (state == DONE);
        case (state)
            IDLE:        if (start) state_nxt = LOAD_REQ;
            LOAD_REQ: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = LOAD_SETUP;
            end
            LOAD_SETUP:  state_nxt = LOAD_HOLD;
            LOAD_HOLD:   if (hold_end) state_nxt = load_last ? SETTLE : LOAD_REQ;
            SETTLE:      if (settle_end) state_nxt = READ_TOGGLE;
            READ_TOGGLE: state_nxt = READ_HOLD;
            READ_HOLD:   if (hold_end) state_nxt = READ_OUT;
            READ_OUT:    if (out_ready) state_nxt = resp_last ? DONE : READ_TOGGLE;
            DONE:        state_nxt = IDLE;
            default:     state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= '0;
            tmr         <= '0;
            link_data   <= '0;
            link_strobe <= 1'b0;
            out_data    <= '0;
            out_valid   <= 1'b0;
        end else begin
            state <= state_nxt;
            // Timer only runs while dwelling in a timed state; any transition restarts it.
            if ((state == LOAD_HOLD || state == SETTLE || state == READ_HOLD) && state_nxt == state)
                tmr <= tmr + TW'(1);
            else
                tmr <= '0;
            case (state)
                IDLE:     if (start) cnt <= '0;
                LOAD_REQ: if (in_valid) begin
                    link_data <= in_data;
                    cnt       <= cnt + CW'(1);
                end
                LOAD_SETUP, READ_TOGGLE: link_strobe <= ~link_strobe;
                // Counter is reused for response bytes once the load phase ends.
                LOAD_HOLD: if (hold_end && load_last) cnt <= '0;
                READ_HOLD: if (hold_end) begin
                    out_data  <= link_rdata;
                    out_valid <= 1'b1;
                end
                READ_OUT: if (out_ready) begin
                    out_valid <= 1'b0;
                    cnt       <= cnt + CW'(1);
                end
                default: ;
            endcase
        end
    end

`ifdef QC_LINK_CKSUM_EN
    logic [7:0] acc;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)                                acc <= '0;
        else if (state == IDLE && start)          acc <= '0;
        else if (state == LOAD_REQ && in_valid)   acc <= acc ^ in_data;
        else if (state == READ_OUT && out_ready)  acc <= acc ^ out_data;
    end

    assign cksum = acc;
`else
    assign cksum = 8'h00;
`endif

endmodule

// File: tb/tb_qc_link_driver.sv
// Directed bench for qc_link_driver with a behavioural model of the far-end FSM
// and queue-based scoreboards for load bytes and readback bytes.
module tb_qc_link_driver;
    localparam int N      = 2;
    localparam int HOLD   = 4;
    localparam int SETTLE = 8;
    localparam int V      = 2 ** N;
    localparam int LB     = 2 * (V + V * V);
    localparam int RB     = 2 * V;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_valid = 1'b0;
    logic       out_ready = 1'b0;
    logic [7:0] link_rdata = 8'h00;
    logic       in_ready, out_valid, link_strobe, busy, done;
    logic [7:0] out_data, link_data, cksum;

    qc_link_driver #(.N(N), .HOLD_CYCLES(HOLD), .SETTLE_CYCLES(SETTLE)) dut (
        .clk(clk), .reset(reset), .start(start),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .link_data(link_data), .link_strobe(link_strobe), .link_rdata(link_rdata),
        .busy(busy), .done(done), .cksum(cksum)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    logic [7:0] ld_buf[LB];
    logic [7:0] cap[LB];
    logic [7:0] ld_q[$];
    logic [7:0] exp_q[$];
    bit         chk_timing = 1'b0;
    bit         ovr_en = 1'b0;
    logic [7:0] ovr_val = 8'h00;
    logic [7:0] cks_exp;
    int         done_cnt = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] src(input bit use_cap, input int i);
        return use_cap ? cap[i] : ld_buf[i];
    endfunction

    // Complex matrix-vector product, products and sums truncated to 8 bits.
    function automatic logic [7:0] calc(input bit use_cap, input int k);
        int row, re, im;
        row = k / 2;
        re = 0;
        im = 0;
        for (int c = 0; c < V; c++) begin
            int sr, si, gr, gi;
            sr = int'($signed(src(use_cap, 2 * c)));
            si = int'($signed(src(use_cap, 2 * c + 1)));
            gr = int'($signed(src(use_cap, 2 * V + 2 * (row * V + c))));
            gi = int'($signed(src(use_cap, 2 * V + 2 * (row * V + c) + 1)));
            re += gr * sr - gi * si;
            im += gr * si + gi * sr;
        end
        return (k % 2 == 0) ? re[7:0] : im[7:0];
    endfunction

    // Far-end FSM model: captures load bytes on strobe toggles, answers readback toggles.
    int mcnt = 0, cyc = 0, ld_chg = 0, last_tog = 0;
    logic prev_sb = 1'b0;
    logic [7:0] prev_ld = 8'h00;
    always @(negedge clk) begin
        cyc++;
        if (reset) begin
            mcnt = 0;
            prev_sb = 1'b0;
            prev_ld = 8'h00;
        end else begin
            done_cnt += int'(done);
            if (link_data !== prev_ld) ld_chg = cyc;
            if (link_strobe !== prev_sb) begin
                if (mcnt < LB) begin
                    cap[mcnt] = link_data;
                    if (ld_q.size() > 0) check("load_byte", link_data, ld_q.pop_front());
                    else check("load_unexpected", 0, 1);
                    check("strobe_level", link_strobe, (mcnt % 2 == 0) ? 1 : 0);
                    if (chk_timing) begin
                        check("data_setup", cyc - ld_chg, 1);
                        if (mcnt > 0) check("strobe_period", cyc - last_tog, HOLD + 2);
                    end
                end else begin
                    link_rdata = ovr_en ? ovr_val : calc(1'b1, mcnt - LB);
                end
                last_tog = cyc;
                mcnt++;
                if (mcnt == LB + RB) mcnt = 0;
            end
            prev_sb = link_strobe;
            prev_ld = link_data;
        end
    end

    task automatic check_reset_vals();
        check("rst_strobe", link_strobe, 0);
        check("rst_link_data", link_data, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_cksum", cksum, 0);
    endtask

    task automatic send(input int nbytes, input bit gaps);
        int to;
        for (int i = 0; i < nbytes; i++) begin
            if (gaps && $urandom_range(0, 2) == 0) begin
                in_valid = 1'b0;
                repeat ($urandom_range(1, 5)) @(negedge clk);
            end
            in_valid = 1'b1;
            in_data  = ld_buf[i];
            ld_q.push_back(ld_buf[i]);
            to = 0;
            while (!in_ready && to < 200) begin
                @(negedge clk);
                to++;
            end
            if (to >= 200) begin
                check("in_ready_timeout", 0, 1);
                in_valid = 1'b0;
                return;
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
    endtask

    task automatic recv(input int stall_idx);
        int to, stable;
        logic [7:0] d0;
        logic s0;
        out_ready = 1'b1;
        for (int i = 0; i < RB; i++) begin
            to = 0;
            while (!out_valid && to < 200) begin
                @(negedge clk);
                to++;
            end
            if (to >= 200) begin
                check("out_valid_timeout", 0, 1);
                return;
            end
            if (i == stall_idx) begin
                out_ready = 1'b0;
                d0 = out_data;
                s0 = link_strobe;
                stable = 0;
                for (int c = 0; c < 20; c++) begin
                    @(negedge clk);
                    if (out_valid === 1'b1 && out_data === d0 && link_strobe === s0) stable++;
                end
                check("stall_stable_cycles", stable, 20);
                out_ready = 1'b1;
            end
            check("resp_byte", out_data, exp_q.pop_front());
            @(negedge clk);
        end
        out_ready = 1'b0;
    endtask

    function automatic logic [7:0] cks_of_bufs();
        logic [7:0] x;
        x = 8'h00;
        for (int i = 0; i < LB; i++) x ^= ld_buf[i];
        for (int i = 0; i < exp_q.size(); i++) x ^= exp_q[i];
        return x;
    endfunction

    task automatic run_tx(input bit gaps, input int stall_idx, input bit timing);
        int to;
        done_cnt = 0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("start_in_ready", in_ready, 1);
        check("start_strobe", link_strobe, 0);
        check("start_busy", busy, 1);
        chk_timing = timing;
        send(LB, gaps);
        chk_timing = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        recv(stall_idx);
        check("done_high", done, 1);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("start_at_done_ignored", busy, 0);
        to = 0;
        while (busy && to < 100) begin
            @(negedge clk);
            to++;
        end
        check("idle_after_tx", busy, 0);
        check("done_pulse_count", done_cnt, 1);
        check("end_strobe", link_strobe, 0);
        check("end_out_valid", out_valid, 0);
`ifdef QC_LINK_CKSUM_EN
        check("cksum", cksum, cks_exp);
`else
        check("cksum_tied", cksum, 0);
`endif
    endtask

    initial begin
        reset = 1'b1;
        @(negedge clk);
        check_reset_vals();
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Ramp 0x01..0x28 back-to-back with link timing checks.
        for (int i = 0; i < LB; i++) ld_buf[i] = 8'(i + 1);
        for (int k = 0; k < RB; k++) exp_q.push_back(calc(1'b0, k));
        cks_exp = cks_of_bufs();
        run_tx(1'b0, -1, 1'b1);

        // State [1,0,0,0] through identity gate, upstream gaps, downstream stall at byte 3.
        for (int i = 0; i < LB; i++) ld_buf[i] = 8'h00;
        ld_buf[0] = 8'h01;
        for (int r = 0; r < V; r++) ld_buf[2 * V + 2 * (r * V + r)] = 8'h01;
        exp_q.push_back(8'h01);
        for (int k = 1; k < RB; k++) exp_q.push_back(8'h00);
        cks_exp = cks_of_bufs();
        run_tx(1'b1, 3, 1'b0);

        // Reset after load byte 17, then a fresh random transaction.
        for (int i = 0; i < LB; i++) ld_buf[i] = 8'($urandom_range(0, 255));
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        send(17, 1'b0);
        reset = 1'b1;
        #1;
        check_reset_vals();
        repeat (2) @(negedge clk);
        ld_q.delete();
        exp_q.delete();
        reset = 1'b0;
        @(negedge clk);
        for (int i = 0; i < LB; i++) ld_buf[i] = 8'($urandom_range(0, 255));
        for (int k = 0; k < RB; k++) exp_q.push_back(calc(1'b0, k));
        cks_exp = cks_of_bufs();
        run_tx(1'b0, -1, 1'b0);

`ifdef QC_LINK_CKSUM_EN
        ovr_en = 1'b1;
        ovr_val = 8'h0F;
        for (int i = 0; i < LB; i++) ld_buf[i] = 8'h55;
        for (int k = 0; k < RB; k++) exp_q.push_back(8'h0F);
        cks_exp = 8'h00;
        run_tx(1'b0, -1, 1'b0);

        ovr_val = 8'h00;
        for (int i = 0; i < LB; i++) ld_buf[i] = 8'h00;
        ld_buf[5] = 8'hA5;
        for (int k = 0; k < RB; k++) exp_q.push_back(8'h00);
        cks_exp = 8'hA5;
        run_tx(1'b0, -1, 1'b0);
        ovr_en = 1'b0;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
